// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction-fetch stage.
//   Global macros: `NOP, `RESET_PC, `IMEM_ADDR_WIDTH (the last is used by the
//   instruction memory only).
//   Optional feature macro: IF_MISALIGN_EXC_EN adds a misalign flag to IF/ID.
`ifndef MIPS_GLOBAL_DEFINES
`define MIPS_GLOBAL_DEFINES
`define NOP             32'h0000_0000
`define RESET_PC        32'h0000_0000
`define IMEM_ADDR_WIDTH 12
`endif

package if_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PC_STEP   = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = `NOP;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
`ifdef IF_MISALIGN_EXC_EN
    logic            misalign;
`endif
  } if_id_t;

  localparam int unsigned IF_ID_W = $bits(if_id_t);

  // Sequential successor of a pc, wrapping modulo 2^32
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(PC_STEP);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: generic inter-stage pipeline register.
//   clk, rst    : clock, synchronous active-high reset (loads RST_VAL)
//   load        : capture d
//   bubble      : capture bubble_d (wins over load)
//   d, bubble_d : normal and bubble payloads
//   q           : registered payload
// With neither load nor bubble the register holds (stall).
module if_id_reg #(
  parameter int unsigned W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] d,
  input  logic [W-1:0] bubble_d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)         q <= RST_VAL;
    else if (bubble) q <= bubble_d;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage.
//   Owns the PC, drives the combinational instruction memory and captures the
//   returned word into the IF/ID register. Handles stalls, ID redirects with a
//   one-entry pending buffer (for redirects arriving while stalled) and flushes.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   stall                       : hold pc and IF/ID
//   redirect_valid, redirect_pc : branch/jump target from ID
//   flush, flush_pc             : restart from a later stage
//   iaddr, idata                : instruction memory address / returned word
//   if_id_instr/pc/pc4/valid    : IF/ID register outputs
//   if_id_misalign              : only with IF_MISALIGN_EXC_EN defined
// Parameters:
//   RESET_PC   : pc after reset
//   DELAY_SLOT : 1 keeps the word fetched in the redirect cycle, 0 squashes it
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = `RESET_PC,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
`ifdef IF_MISALIGN_EXC_EN
  output logic        if_id_misalign,
`endif
  output logic        if_id_valid
);

  logic [31:0] pc, pc_n, pc4;
  logic        pend_valid, pend_valid_n;
  logic [31:0] pend_pc, pend_pc_n;

  logic        ifid_load, ifid_bubble;
  if_id_t      fetch_d, bubble_d, ifid_q;

  assign pc4 = pc_plus4(pc);

  // Memory address comes straight from the pc register
`ifdef IF_MISALIGN_EXC_EN
  assign iaddr = pc;
`else
  assign iaddr = {pc[31:2], 2'b00};
`endif

  // PC and pending-redirect state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
    end else begin
      pc         <= pc_n;
      pend_valid <= pend_valid_n;
      pend_pc    <= pend_pc_n;
    end
  end

  // Fetched word payload; a misaligned pc becomes a flagged NOP
  always_comb begin
    fetch_d       = '0;
    fetch_d.instr = idata;
    fetch_d.pc    = pc;
    fetch_d.pc4   = pc4;
    fetch_d.valid = 1'b1;
`ifdef IF_MISALIGN_EXC_EN
    if (pc[1:0] != 2'b00) begin
      fetch_d.instr    = NOP_INSTR;
      fetch_d.misalign = 1'b1;
    end
`endif
  end

  // Next-pc selection and IF/ID control, flush > stall > redirect > pending
  always_comb begin
    pc_n           = pc4;
    pend_valid_n   = pend_valid;
    pend_pc_n      = pend_pc;
    ifid_load      = 1'b1;
    ifid_bubble    = 1'b0;
    bubble_d       = '0;
    bubble_d.instr = NOP_INSTR;
    bubble_d.pc    = pc;
    bubble_d.pc4   = pc4;
    bubble_d.valid = 1'b0;

    if (flush) begin
      pc_n         = flush_pc;
      pend_valid_n = 1'b0;
      ifid_bubble  = 1'b1;
      bubble_d.pc  = flush_pc;
      bubble_d.pc4 = pc_plus4(flush_pc);
    end else if (stall) begin
      pc_n      = pc;
      ifid_load = 1'b0;
      // Remember the latest redirect until the stall releases
      if (redirect_valid) begin
        pend_valid_n = 1'b1;
        pend_pc_n    = redirect_pc;
      end
    end else if (redirect_valid) begin
      pc_n         = redirect_pc;
      pend_valid_n = 1'b0;
      ifid_bubble  = !DELAY_SLOT;
    end else if (pend_valid) begin
      pc_n         = pend_pc;
      pend_valid_n = 1'b0;
    end
  end

  if_id_reg #(
    .W       (IF_ID_W),
    .RST_VAL (IF_ID_W'(0))
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .d        (fetch_d),
    .bubble_d (bubble_d),
    .q        (ifid_q)
  );

  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc       = ifid_q.pc;
  assign if_id_pc4      = ifid_q.pc4;
  assign if_id_valid    = ifid_q.valid;
`ifdef IF_MISALIGN_EXC_EN
  assign if_id_misalign = ifid_q.misalign;
`endif

endmodule
